issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Sits between the decode stage and execute; sequences decoded instructions into execute.
- Holds one decoded instruction and tracks destination registers with outstanding writeback in a per-register scoreboard.
- Stalls issue on RAW/WAW hazards and releases it when writeback clears them.
- Uses a valid/ready handshake on both sides, with a flush for redirects.

Parameters:
- NUM_REGS, 32, number of architectural integer registers; x0 is never tracked.
- REG_W, 5, register index width (clog2 of NUM_REGS).
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock; all state on rising edge
- resetn  input  1  asynchronous active-low reset
- dec_valid_i  input  1  decoded instruction valid
- dec_ready_o  output  1  block accepts the decoded instruction this cycle
- dec_instr_i  input  32  raw instruction bits, carried through
- dec_imm_i  input  32  decoded immediate, carried through
- dec_rs1_i  input  REG_W  source register 1
- dec_rs2_i  input  REG_W  source register 2
- dec_rd_i  input  REG_W  destination register
- dec_type_i  input  6  one-hot {j,u,b,s,i,r} instruction-type flags
- ex_valid_o  output  1  instruction issued to execute
- ex_ready_i  input  1  execute accepts
- ex_instr_o  output  32  held instruction bits
- ex_imm_o  output  32  held immediate
- ex_rd_o  output  REG_W  held destination
- ex_wr_rd_o  output  1  held instruction writes a non-zero rd
- wb_valid_i  input  1  writeback retiring a register write
- wb_rd_i  input  REG_W  register being written back
- flush_i  input  1  discard held instruction and all pending state
- state_o  output  2  FSM state: 0 EMPTY, 1 READY, 2 STALL
- stall_cnt_o  output  CNT_W  saturating count of cycles spent in STALL

Behaviour:
- Reset: clock is clk; reset resetn is asynchronous, active-low.
  - hold_valid=0, pending[NUM_REGS-1:0]=0, state=EMPTY, stall_cnt_o=0.
  - All ex_* outputs 0; dec_ready_o=1 after reset deasserts.
- Derived from dec_type_i at capture and registered with the entry:
  - uses_rs1 = r|i|s|b.
  - uses_rs2 = r|s|b.
  - wr_rd = (r|i|u|j) && rd!=0.
- hazard (combinational on the held entry) = (uses_rs1 && pending[rs1]) || (uses_rs2 && pending[rs2]) || (wr_rd && pending[rd]).
  - The last term is the WAW check.
- ex_valid_o = hold_valid && !hazard && !flush_i.
- fire = ex_valid_o && ex_ready_i.
- dec_ready_o = (!hold_valid || fire) && !flush_i.
- Accept:
  - dec_valid_i && dec_ready_o captures all dec_* fields into the holding register the next edge.
  - Capture and fire in the same cycle is allowed, giving back-to-back issue at 1/cycle.
- Issue latency: minimum 1 cycle from accept to ex_valid_o. ex_* outputs are registered and stable while ex_valid_o && !ex_ready_i.
- Scoreboard update each edge:
  - fire && ex_wr_rd_o sets pending[ex_rd_o].
  - wb_valid_i && wb_rd_i!=0 clears pending[wb_rd_i].
  - Set and clear of the same index in one cycle: set wins.
  - pending[0] is hardwired 0.
  - wb_valid_i for a non-pending register is a no-op.
- FSM, next state:
  - EMPTY when no entry is held.
  - READY when an entry is held and hazard=0.
  - STALL when an entry is held and hazard=1.
  - state_o reflects the current registered state.
- stall_cnt_o increments by 1 each cycle state==STALL and saturates at all-ones.
- Flush:
  - flush_i has priority over every other event.
  - Next edge: hold_valid=0, pending=0, state=EMPTY.
  - Same-cycle dec_valid_i is not accepted; the fire is suppressed, so no pending bit is set.
  - stall_cnt_o is not cleared.
- Reset mid-stall: all state cleared immediately and asynchronously; pending writebacks are lost by design.

Optional Feature:
- Macro: ISSUE_SB_WB_BYPASS_EN.
- Defined: hazard uses pending & ~wbclr, where wbclr is the one-hot of wb_rd_i when wb_valid_i. A stalled instruction issues in the same cycle its blocking writeback arrives.
- Undefined: hazard uses the registered pending only, so issue occurs at the earliest one cycle after the clearing writeback.

Test Plan:
- Reset then a stream of 4 independent ADDs (rd=1..4, rs=0), ex_ready_i=1 -> ex_valid_o high 4 consecutive cycles starting 1 cycle after first accept; pending=0x1E afterwards.
- ADD rd=5, then SUB rs1=5 -> SUB held, state_o=2, stall_cnt_o counts. wb_rd_i=5:
  - without the macro, SUB issues 1 cycle after wb.
  - with ISSUE_SB_WB_BYPASS_EN, SUB issues in the same cycle as wb.
- LUI rd=7 pending, then ADDI rd=7 (WAW) -> stall until wb_rd_i=7. Instruction with rd=0 never sets pending and never stalls on rd.
- Held READY instruction with ex_ready_i=0 for 3 cycles -> ex_* stable, dec_ready_o=0. ex_ready_i=1 with dec_valid_i=1 -> fire and capture in the same cycle.
- Stalled instruction, pending=0x20, flush_i=1 with dec_valid_i=1 -> dec_ready_o=0 that cycle; next cycle state_o=0, pending=0, no ex_valid_o.
- Force 2^CNT_W stall cycles (CNT_W overridden to 4) -> stall_cnt_o saturates at 15. Assert resetn=0 mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Decode/execute/writeback bus of the issue scoreboard.
// The slave side is the scoreboard itself; master is the surrounding pipeline.
interface issue_scoreboard_if #(
  parameter int REG_W = 5
);
  logic             dec_valid_i;
  logic             dec_ready_o;
  logic [31:0]      dec_instr_i;
  logic [31:0]      dec_imm_i;
  logic [REG_W-1:0] dec_rs1_i;
  logic [REG_W-1:0] dec_rs2_i;
  logic [REG_W-1:0] dec_rd_i;
  logic [5:0]       dec_type_i;
  logic             ex_valid_o;
  logic             ex_ready_i;
  logic [31:0]      ex_instr_o;
  logic [31:0]      ex_imm_o;
  logic [REG_W-1:0] ex_rd_o;
  logic             ex_wr_rd_o;
  logic             wb_valid_i;
  logic [REG_W-1:0] wb_rd_i;
  logic             flush_i;

  modport slave (
    input  dec_valid_i, dec_instr_i, dec_imm_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_type_i,
    input  ex_ready_i, wb_valid_i, wb_rd_i, flush_i,
    output dec_ready_o, ex_valid_o, ex_instr_o, ex_imm_o, ex_rd_o, ex_wr_rd_o
  );

  modport master (
    output dec_valid_i, dec_instr_i, dec_imm_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_type_i,
    output ex_ready_i, wb_valid_i, wb_rd_i, flush_i,
    input  dec_ready_o, ex_valid_o, ex_instr_o, ex_imm_o, ex_rd_o, ex_wr_rd_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Single-entry issue stage with a per-register pending-writeback scoreboard.
// Optional macro ISSUE_SB_WB_BYPASS_EN lets a same-cycle writeback unblock issue.
module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  issue_scoreboard_if.slave bus,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_READY = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      imm;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             use1;
    logic             use2;
    logic             wr;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  entry_t              entry_q, entry_d, dec_entry;
  logic                hold_q, hold_d;
  logic [NUM_REGS-1:0] pending_q, pending_d, pend_hz, wbclr, setv;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hazard, ex_valid, fire, dec_ready, accept;

  function automatic logic hazard_f(entry_t e, logic [NUM_REGS-1:0] p);
    return (e.use1 && p[e.rs1]) || (e.use2 && p[e.rs2]) || (e.wr && p[e.rd]);
  endfunction

  // Type flags are {j,u,b,s,i,r}; source/dest usage is resolved once at capture.
  always_comb begin
    dec_entry       = '0;
    dec_entry.instr = bus.dec_instr_i;
    dec_entry.imm   = bus.dec_imm_i;
    dec_entry.rs1   = bus.dec_rs1_i;
    dec_entry.rs2   = bus.dec_rs2_i;
    dec_entry.rd    = bus.dec_rd_i;
    dec_entry.use1  = |bus.dec_type_i[3:0];
    dec_entry.use2  = bus.dec_type_i[0] | bus.dec_type_i[2] | bus.dec_type_i[3];
    dec_entry.wr    = (bus.dec_type_i[0] | bus.dec_type_i[1] | bus.dec_type_i[4] |
                       bus.dec_type_i[5]) && (bus.dec_rd_i != '0);
  end

  always_comb begin
    wbclr = '0;
    if (bus.wb_valid_i && bus.wb_rd_i != '0) wbclr[bus.wb_rd_i] = 1'b1;
  end

`ifdef ISSUE_SB_WB_BYPASS_EN
  assign pend_hz = pending_q & ~wbclr;
`else
  assign pend_hz = pending_q;
`endif

  always_comb begin
    hazard    = hazard_f(entry_q, pend_hz);
    ex_valid  = hold_q && !hazard && !bus.flush_i;
    fire      = ex_valid && bus.ex_ready_i;
    dec_ready = (!hold_q || fire) && !bus.flush_i;
    accept    = bus.dec_valid_i && dec_ready;
    setv      = '0;
    if (fire && entry_q.wr) setv[entry_q.rd] = 1'b1;
    entry_d   = accept ? dec_entry : entry_q;
    if (bus.flush_i) begin
      hold_d    = 1'b0;
      pending_d = '0;
    end else begin
      hold_d    = accept ? 1'b1 : (fire ? 1'b0 : hold_q);
      // Set is OR-ed after the clear so a same-index set wins.
      pending_d = (pending_q & ~wbclr) | setv;
    end
    pending_d[0] = 1'b0;
  end

  // State tracks the entry that will be held next cycle against next-cycle pending.
  always_comb begin
    state_d = ST_EMPTY;
    if (hold_d) state_d = hazard_f(entry_d, pending_d) ? ST_STALL : ST_READY;
    cnt_d = cnt_q;
    if (state_q == ST_STALL && cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry_q   <= '0;
      hold_q    <= 1'b0;
      pending_q <= '0;
      state_q   <= ST_EMPTY;
      cnt_q     <= '0;
    end else begin
      entry_q   <= entry_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.dec_ready_o = dec_ready;
  assign bus.ex_valid_o  = ex_valid;
  assign bus.ex_instr_o  = entry_q.instr;
  assign bus.ex_imm_o    = entry_q.imm;
  assign bus.ex_rd_o     = entry_q.rd;
  assign bus.ex_wr_rd_o  = entry_q.wr;
  assign state_o         = state_q;
  assign stall_cnt_o     = cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus random traffic
// compared each cycle against a behavioural model of the issue rules.
module tb_issue_scoreboard;
  localparam int CW = 4;
`ifdef ISSUE_SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam bit [5:0] T_R = 6'b000001, T_I = 6'b000010, T_U = 6'b010000;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt;

  issue_scoreboard_if #(.REG_W(5)) bus ();
  issue_scoreboard #(.NUM_REGS(32), .REG_W(5), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .state_o(state_o), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] instr;
    bit [31:0] imm;
    int        rs1, rs2, rd;
    bit        u1, u2, wr;
  } ent_t;

  int        n_assert = 0;
  int        n_fail   = 0;
  bit        m_hold;
  ent_t      m_e;
  bit        m_pend [32];
  int        m_state;
  int        m_cnt;

  bit        s_dv, s_exr, s_wbv, s_fl;
  bit [31:0] s_instr, s_imm;
  int        s_rs1, s_rs2, s_rd, s_wbrd;
  bit [5:0]  s_typ;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t decode();
    ent_t e;
    e.instr = s_instr; e.imm = s_imm;
    e.rs1 = s_rs1; e.rs2 = s_rs2; e.rd = s_rd;
    e.u1 = s_typ[0] | s_typ[1] | s_typ[2] | s_typ[3];
    e.u2 = s_typ[0] | s_typ[2] | s_typ[3];
    e.wr = (s_typ[0] | s_typ[1] | s_typ[4] | s_typ[5]) && (s_rd != 0);
    return e;
  endfunction

  function automatic bit busy(int r, bit byp);
    if (r == 0) return 1'b0;
    if (byp && s_wbv && s_wbrd == r) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic bit blocked(ent_t e, bit byp);
    return (e.u1 && busy(e.rs1, byp)) || (e.u2 && busy(e.rs2, byp)) ||
           (e.wr && busy(e.rd, byp));
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v = '0;
    for (int r = 1; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  task automatic model_reset();
    m_hold = 0; m_state = 0; m_cnt = 0; m_e = '{default: 0};
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
  endtask

  task automatic dec(int rs1, int rs2, int rd, bit [5:0] t, bit [31:0] instr);
    s_dv = 1; s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_typ = t;
    s_instr = instr; s_imm = $urandom;
  endtask

  task automatic step();
    bit exv, fire, dr;
    logic [4:0] a, b, c, w;
    a = s_rs1[4:0]; b = s_rs2[4:0]; c = s_rd[4:0]; w = s_wbrd[4:0];
    bus.dec_valid_i = s_dv;  bus.dec_instr_i = s_instr; bus.dec_imm_i = s_imm;
    bus.dec_rs1_i = a; bus.dec_rs2_i = b; bus.dec_rd_i = c; bus.dec_type_i = s_typ;
    bus.ex_ready_i = s_exr; bus.wb_valid_i = s_wbv; bus.wb_rd_i = w; bus.flush_i = s_fl;
    @(negedge clk);
    exv  = m_hold && !blocked(m_e, BYP) && !s_fl;
    fire = exv && s_exr;
    dr   = (!m_hold || fire) && !s_fl;
    chk("ex_valid", bus.ex_valid_o, exv);
    chk("dec_ready", bus.dec_ready_o, dr);
    chk("state", state_o, m_state);
    chk("stall_cnt", stall_cnt, m_cnt);
    if (exv) begin
      chk("ex_instr", bus.ex_instr_o, m_e.instr);
      chk("ex_imm", bus.ex_imm_o, m_e.imm);
      chk("ex_rd", bus.ex_rd_o, m_e.rd);
      chk("ex_wr_rd", bus.ex_wr_rd_o, m_e.wr);
    end
    @(posedge clk);
    if (m_state == 2 && m_cnt != (1 << CW) - 1) m_cnt++;
    if (s_fl) begin
      m_hold = 0;
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
    end else begin
      if (s_wbv && s_wbrd != 0) m_pend[s_wbrd] = 0;
      if (fire && m_e.wr) m_pend[m_e.rd] = 1;
      if (s_dv && dr) begin
        m_e = decode(); m_hold = 1;
      end else if (fire) m_hold = 0;
    end
    m_state = m_hold ? (blocked(m_e, 1'b0) ? 2 : 1) : 0;
    #1;
  endtask

  initial begin
    s_dv = 0; s_exr = 1; s_wbv = 0; s_fl = 0; s_instr = 0; s_imm = 0;
    s_rs1 = 0; s_rs2 = 0; s_rd = 0; s_wbrd = 0; s_typ = 0;
    bus.dec_valid_i = 0; bus.dec_instr_i = 0; bus.dec_imm_i = 0; bus.dec_rs1_i = 0;
    bus.dec_rs2_i = 0; bus.dec_rd_i = 0; bus.dec_type_i = 0; bus.ex_ready_i = 1;
    bus.wb_valid_i = 0; bus.wb_rd_i = 0; bus.flush_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", bus.ex_valid_o, 0);
    chk("rst_state", state_o, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_ex_instr", bus.ex_instr_o, 0);
    chk("rst_ex_imm", bus.ex_imm_o, 0);
    chk("rst_ex_rd", bus.ex_rd_o, 0);
    chk("rst_ex_wr_rd", bus.ex_wr_rd_o, 0);
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;

    // Four independent ADDs, back to back
    for (int i = 1; i <= 4; i++) begin
      dec(0, 0, i, T_R, 32'h0000_0033 + i);
      step();
    end
    s_dv = 0; step(); step();
    chk("pend_1e", dut.pending_q, 32'h0000_001E);

    // RAW: ADD x5 then SUB reading x5
    dec(0, 0, 5, T_R, 32'h0050_02B3); step();
    dec(5, 0, 6, T_R, 32'h4000_0333); step();
    s_dv = 0; repeat (4) step();
    chk("raw_stall_state", state_o, 2);
    s_wbv = 1; s_wbrd = 5; step();
    s_wbv = 0; step(); step();

    // WAW: LUI x7 then ADDI x7; then an rd=0 instruction
    dec(0, 0, 7, T_U, 32'h0000_13B7); step();
    dec(0, 0, 7, T_I, 32'h0010_0393); step();
    s_dv = 0; repeat (3) step();
    chk("waw_stall_state", state_o, 2);
    s_wbv = 1; s_wbrd = 7; step();
    s_wbv = 0; step();
    dec(0, 0, 0, T_I, 32'h0000_0013); step();
    s_dv = 0; step(); step();
    chk("pend_model_a", dut.pending_q, pend_vec());

    // Back-pressure from execute, then fire and capture together
    s_exr = 0;
    dec(0, 0, 8, T_R, 32'h0000_0433); step();
    dec(0, 0, 9, T_R, 32'h0000_04B3);
    repeat (3) step();
    s_exr = 1; step();
    s_dv = 0; step(); step();

    // Flush of a stalled instruction with decode valid in the same cycle
    s_fl = 1; step(); s_fl = 0;
    dec(0, 0, 5, T_R, 32'h0050_02B3); step();
    dec(5, 0, 6, T_R, 32'h4000_0333); step();
    s_dv = 0; step(); step();
    chk("pend_20", dut.pending_q, 32'h0000_0020);
    s_fl = 1; dec(0, 0, 9, T_R, 32'h0000_04B3); step();
    s_fl = 0; s_dv = 0; step();
    chk("flush_state", state_o, 0);
    chk("flush_pend", dut.pending_q, 0);

    // Long stall saturates the counter, then asynchronous reset mid-stall
    dec(0, 0, 10, T_R, 32'h0000_0533); step();
    dec(10, 0, 11, T_R, 32'h0000_05B3); step();
    s_dv = 0; repeat (20) step();
    chk("cnt_sat", stall_cnt, 15);
    #2 resetn = 0; #1;
    chk("arst_state", state_o, 0);
    chk("arst_cnt", stall_cnt, 0);
    chk("arst_ex_valid", bus.ex_valid_o, 0);
    chk("arst_ex_instr", bus.ex_instr_o, 0);
    chk("arst_ex_rd", bus.ex_rd_o, 0);
    chk("arst_ex_wr_rd", bus.ex_wr_rd_o, 0);
    chk("arst_pend", dut.pending_q, 0);
    model_reset();
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      s_dv    = ($urandom % 4) != 0;
      s_rs1   = $urandom % 8; s_rs2 = $urandom % 8; s_rd = $urandom % 8;
      s_typ   = 6'b000001 << ($urandom % 6);
      s_instr = $urandom; s_imm = $urandom;
      s_exr   = ($urandom % 4) != 0;
      s_wbv   = ($urandom % 3) == 0;
      s_wbrd  = $urandom % 8;
      s_fl    = ($urandom % 50) == 0;
      step();
    end
    chk("pend_model_end", dut.pending_q, pend_vec());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
